// File: rtl/gpu_pkg.sv
// Shared GPU core definitions.
// Holds the default program-memory geometry, the warp id type used by both
// the fetch stage and the warp scheduler, and the fetch-stage state encoding.
package gpu_pkg;

    localparam int DEFAULT_MAX_WARPS_PER_CORE    = 2;
    localparam int DEFAULT_PROGRAM_MEM_ADDR_BITS = 8;
    localparam int DEFAULT_PROGRAM_MEM_DATA_BITS = 16;
    localparam int DEFAULT_WARP_ID_BITS          =
        (DEFAULT_MAX_WARPS_PER_CORE > 1) ? $clog2(DEFAULT_MAX_WARPS_PER_CORE) : 1;

    typedef logic [DEFAULT_WARP_ID_BITS-1:0] warp_id_t;

    typedef enum logic [2:0] {
        FS_IDLE     = 3'd0,
        FS_LOOKUP   = 3'd1,
        FS_WAIT_MEM = 3'd2,
        FS_READY    = 3'd3,
        FS_DRAIN    = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/warp_fetcher_buffer.sv
// fetch_buffer: one instruction entry per warp, each {valid, tag(pc), data}.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   lookup_warp_i/tag_i   combinational lookup key
//   lookup_hit_o/data_o   hit flag and stored instruction for that warp
//   write_en_i, write_*   fill one warp's entry on the next edge
//   invalidate_i          clear every valid bit on the next edge
// A write and an invalidate in the same cycle leave the entry invalid.
module fetch_buffer
    import gpu_pkg::*;
#(
    parameter int NUM_ENTRIES = DEFAULT_MAX_WARPS_PER_CORE,
    parameter int WID_BITS    = DEFAULT_WARP_ID_BITS,
    parameter int TAG_BITS    = DEFAULT_PROGRAM_MEM_ADDR_BITS,
    parameter int DATA_BITS   = DEFAULT_PROGRAM_MEM_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WID_BITS-1:0]  lookup_warp_i,
    input  logic [TAG_BITS-1:0]  lookup_tag_i,
    output logic                 lookup_hit_o,
    output logic [DATA_BITS-1:0] lookup_data_o,
    input  logic                 write_en_i,
    input  logic [WID_BITS-1:0]  write_warp_i,
    input  logic [TAG_BITS-1:0]  write_tag_i,
    input  logic [DATA_BITS-1:0] write_data_i,
    input  logic                 invalidate_i
);

    logic [NUM_ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_BITS-1:0]    tag_q  [NUM_ENTRIES];
    logic [DATA_BITS-1:0]   data_q [NUM_ENTRIES];

    // Lookup reads the registered valid bits, so an invalidate raised in the
    // same cycle as a lookup does not affect that lookup.
    assign lookup_hit_o  = valid_q[lookup_warp_i] && (tag_q[lookup_warp_i] == lookup_tag_i);
    assign lookup_data_o = data_q[lookup_warp_i];

    always_comb begin
        valid_d = valid_q;
        if (write_en_i) begin
            valid_d[write_warp_i] = 1'b1;
        end
        // Invalidate applied last so it overrides a coincident fill.
        if (invalidate_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            if (write_en_i) begin
                tag_q[write_warp_i]  <= write_tag_i;
                data_q[write_warp_i] <= write_data_i;
            end
        end
    end

endmodule

// File: rtl/warp_fetcher.sv
// warp_fetcher: per-core instruction fetch stage ahead of the warp scheduler.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   fetch_req, warp_id, pc      request from the scheduler (held until ready)
//   invalidate                  drop all buffered instructions
//   mem_read_valid/address      read request to program memory
//   mem_read_ready/data         program memory response
//   instruction_ready/instr.    result level sampled by the scheduler
//   hit_count                   saturating count of buffer hits
//   state_dbg                   current FSM state (fetch_state_e encoding)
// Memory handshake: mem_read_valid rises with a stable mem_read_address and
// both hold until the cycle mem_read_ready is 1; that cycle carries the data
// and completes the read. At most one read is outstanding, and a read once
// issued always completes even if the scheduler withdraws its request.
module warp_fetcher
    import gpu_pkg::*;
#(
    parameter int MAX_WARPS_PER_CORE    = DEFAULT_MAX_WARPS_PER_CORE,
    parameter int PROGRAM_MEM_ADDR_BITS = DEFAULT_PROGRAM_MEM_ADDR_BITS,
    parameter int PROGRAM_MEM_DATA_BITS = DEFAULT_PROGRAM_MEM_DATA_BITS,
    parameter int WARP_ID_BITS          =
        (MAX_WARPS_PER_CORE > 1) ? $clog2(MAX_WARPS_PER_CORE) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             fetch_req,
    input  logic [WARP_ID_BITS-1:0]          warp_id,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] pc,
    input  logic                             invalidate,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic                             instruction_ready,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [7:0]                       hit_count,
    output logic [2:0]                       state_dbg
);

    fetch_state_e state_q, state_d;

    logic [WARP_ID_BITS-1:0]          req_warp_q, req_warp_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] req_pc_q, req_pc_d;
    logic                             mem_valid_q, mem_valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic                             instr_ready_q, instr_ready_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0] instr_q, instr_d;
    logic [7:0]                       hit_count_q, hit_count_d;

    logic                             buf_hit;
    logic [PROGRAM_MEM_DATA_BITS-1:0] buf_data;
    logic                             buf_we;

    fetch_buffer #(
        .NUM_ENTRIES (MAX_WARPS_PER_CORE),
        .WID_BITS    (WARP_ID_BITS),
        .TAG_BITS    (PROGRAM_MEM_ADDR_BITS),
        .DATA_BITS   (PROGRAM_MEM_DATA_BITS)
    ) u_buffer (
        .clk           (clk),
        .reset         (reset),
        .lookup_warp_i (req_warp_q),
        .lookup_tag_i  (req_pc_q),
        .lookup_hit_o  (buf_hit),
        .lookup_data_o (buf_data),
        .write_en_i    (buf_we),
        .write_warp_i  (req_warp_q),
        .write_tag_i   (req_pc_q),
        .write_data_i  (mem_read_data),
        .invalidate_i  (invalidate)
    );

    always_comb begin
        state_d       = state_q;
        req_warp_d    = req_warp_q;
        req_pc_d      = req_pc_q;
        mem_valid_d   = mem_valid_q;
        mem_addr_d    = mem_addr_q;
        instr_ready_d = instr_ready_q;
        instr_d       = instr_q;
        hit_count_d   = hit_count_q;
        buf_we        = 1'b0;

        unique case (state_q)
            FS_IDLE: begin
                if (fetch_req) begin
                    req_warp_d = warp_id;
                    req_pc_d   = pc;
                    state_d    = FS_LOOKUP;
                end else if (invalidate) begin
                    state_d = FS_DRAIN;
                end
            end

            FS_LOOKUP: begin
                if (!fetch_req) begin
                    state_d = FS_IDLE;
                end else if (buf_hit) begin
                    instr_d       = buf_data;
                    instr_ready_d = 1'b1;
                    if (hit_count_q != 8'hFF) begin
                        hit_count_d = hit_count_q + 8'd1;
                    end
                    state_d = FS_READY;
                end else begin
                    mem_valid_d = 1'b1;
                    mem_addr_d  = req_pc_q;
                    state_d     = FS_WAIT_MEM;
                end
            end

            FS_WAIT_MEM: begin
                if (mem_read_ready) begin
                    mem_valid_d = 1'b0;
                    buf_we      = 1'b1;
                    if (fetch_req) begin
                        instr_d       = mem_read_data;
                        instr_ready_d = 1'b1;
                        state_d       = FS_READY;
                    end else begin
                        // Scheduler gave up: keep the fill, deliver nothing.
                        state_d = FS_IDLE;
                    end
                end
            end

            FS_READY: begin
                if (!fetch_req) begin
                    instr_ready_d = 1'b0;
                    state_d       = FS_IDLE;
                end
            end

            FS_DRAIN: begin
                state_d = FS_IDLE;
            end

            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FS_IDLE;
            req_warp_q    <= '0;
            req_pc_q      <= '0;
            mem_valid_q   <= 1'b0;
            mem_addr_q    <= '0;
            instr_ready_q <= 1'b0;
            instr_q       <= '0;
            hit_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            req_warp_q    <= req_warp_d;
            req_pc_q      <= req_pc_d;
            mem_valid_q   <= mem_valid_d;
            mem_addr_q    <= mem_addr_d;
            instr_ready_q <= instr_ready_d;
            instr_q       <= instr_d;
            hit_count_q   <= hit_count_d;
        end
    end

    assign mem_read_valid    = mem_valid_q;
    assign mem_read_address  = mem_addr_q;
    assign instruction_ready = instr_ready_q;
    assign instruction       = instr_q;
    assign hit_count         = hit_count_q;
    assign state_dbg         = state_q;

endmodule

// File: doc/warp_fetcher.md
Name: warp_fetcher

Overview:
Per-core instruction fetch stage sitting directly upstream of the warp scheduler. It accepts a fetch request (warp id, pc) while the scheduler is in FETCHING and issues a read to program memory over a valid/ready handshake. It returns the instruction word with an instruction_ready level that the scheduler samples. A one-entry-per-warp instruction buffer skips the memory read when a warp re-fetches the same pc.

Parameters:
MAX_WARPS_PER_CORE, 2, number of warps / buffer entries
PROGRAM_MEM_ADDR_BITS, 8, pc and program-memory address width
PROGRAM_MEM_DATA_BITS, 16, instruction width
WARP_ID_BITS, max(1,$clog2(MAX_WARPS_PER_CORE)), warp id width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
fetch_req  in  1  scheduler in FETCHING state, held until instruction_ready seen
warp_id  in  WARP_ID_BITS  warp being fetched
pc  in  PROGRAM_MEM_ADDR_BITS  pc of that warp
invalidate  in  1  clear all buffer entries (program reload)
mem_read_valid  out  1  read request to program memory
mem_read_address  out  PROGRAM_MEM_ADDR_BITS  read address
mem_read_ready  in  1  memory returns data this cycle
mem_read_data  in  PROGRAM_MEM_DATA_BITS  returned instruction
instruction_ready  out  1  instruction valid for scheduler
instruction  out  PROGRAM_MEM_DATA_BITS  fetched instruction
hit_count  out  8  buffer hits since reset, saturating at 255

Behaviour:
- Reset (async, active-high): state=IDLE; mem_read_valid=0, mem_read_address=0, instruction_ready=0, instruction=0, hit_count=0; all buffer valid bits=0. Reset mid-transaction abandons it; a later mem_read_ready is ignored in IDLE.
- States: IDLE, LOOKUP, WAIT_MEM, READY, DRAIN.
- IDLE: on fetch_req=1, latch warp_id and pc into req_warp/req_pc -> LOOKUP.
- LOOKUP (1 cycle): hit = valid[req_warp] && tag[req_warp]==req_pc. On hit: instruction<=data[req_warp], instruction_ready<=1, hit_count++ (saturating) -> READY. Hit latency: 2 cycles from fetch_req to instruction_ready. On miss: mem_read_valid<=1, mem_read_address<=req_pc -> WAIT_MEM.
- WAIT_MEM: mem_read_valid and address held stable until mem_read_ready=1. On ready: mem_read_valid<=0; write entry req_warp (valid=1, tag=req_pc, data=mem_read_data). If fetch_req still 1: instruction<=mem_read_data, instruction_ready<=1 -> READY; else -> IDLE (fill only, no ready).
- fetch_req dropping in LOOKUP -> IDLE, no ready, no count. Dropping in WAIT_MEM -> transaction completes (memory not abortable), result handled as above.
- READY: instruction_ready and instruction held while fetch_req=1. When fetch_req=0: instruction_ready<=0 -> IDLE. instruction keeps last value.
- warp_id/pc changes while busy are ignored; only latched values used.
- invalidate: clears all valid bits next edge. Same cycle as a WAIT_MEM fill: invalidate wins, entry stays invalid, the instruction is still delivered. During LOOKUP: the lookup uses pre-invalidate valid bits.
- DRAIN: entered from IDLE when invalidate=1 and fetch_req=0; one cycle, then IDLE. Gives a guaranteed empty-buffer cycle. fetch_req during DRAIN is accepted next cycle from IDLE.
- hit_count: 8-bit, saturates at 255, no wrap.
- Only one outstanding memory read at any time.

Decomposition:
- Shared package gpu_pkg: fetcher state enum (3-bit), PROGRAM_MEM_ADDR_BITS/DATA_BITS defaults, and a warp_id type shared with the scheduler.
- Sub-module fetch_buffer: MAX_WARPS_PER_CORE entries of {valid, tag, data}. Combinational lookup port, write port, invalidate-all. The FSM stays in warp_fetcher.

Test Plan:
- Cold miss: fetch_req=1, warp 0, pc=0x05. mem_read_valid rises at cycle 2 with address 0x05. mem_read_ready with data 0xA1B2 after 3 cycles -> next edge instruction_ready=1, instruction=0xA1B2. Drop fetch_req -> ready=0 next edge.
- Hit: refetch warp 0 at pc=0x05 -> no mem_read_valid; instruction_ready=1 two cycles after fetch_req; instruction=0xA1B2; hit_count=1.
- Per-warp isolation: warp 1 at pc=0x05 misses, fills 0x3C3C. Warp 0 at pc=0x05 still hits 0xA1B2. Warp 0 at pc=0x06 misses.
- Abandon: fetch_req dropped in WAIT_MEM. Memory returns 0x7777 -> instruction_ready stays 0, state IDLE. Refetch of the same pc hits with 0x7777.
- Invalidate: after fills, pulse invalidate -> the next fetch of warp 0 pc=0x05 misses. Invalidate coincident with a fill -> data delivered, subsequent refetch misses.
- Reset mid-WAIT_MEM: assert reset asynchronously -> outputs 0 immediately, hit_count=0. A late mem_read_ready is ignored and the next fetch misses.
